// File: rtl/mem_access_arbiter_if.sv
`timescale 1ns/1ps
// Purpose : bundles the fetch port, data port, status and memory-side signals of mem_access_arbiter.
// Latency : none, wires only.
// Backpressure: requesters hold req level until their ack; the memory side has no stall path.
// Ports   : if_req/if_addr/if_ack        instruction fetch port
//           d_req/d_we/d_addr/d_wdata/d_ack  data load/store port
//           rdata/err/busy                shared completion data and status
//           mem_addr/mem_din/mem_re/mem_we/mem_dout  single-port memory connection
// slave modport = arbiter view, master modport = requesters plus memory view.
interface mem_access_arbiter_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 13
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output if_ack, d_ack, rdata, err, busy, mem_addr, mem_din, mem_re, mem_we
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  if_ack, d_ack, rdata, err, busy, mem_addr, mem_din, mem_re, mem_we
  );
endinterface

// File: rtl/mem_access_arbiter.sv
`timescale 1ns/1ps
// Purpose : arbitrates fetch and data ports onto one single-port memory, one operation at a time.
// Latency : request sampled in IDLE at T; read acks at T+3, write or out-of-range acks at T+2.
// Backpressure: requests are level-held until ack; nothing is queued while busy.
// Ports   : clk, rst (async active-low); bus = mem_access_arbiter_if.slave carrying both
//           requester ports, rdata/err/busy and the memory address/data/enable signals.
// All outputs come straight from flops.
module mem_access_arbiter #(
  parameter int DATA_W     = 18,
  parameter int ADDR_W     = 13,
  parameter int DEPTH_LOG2 = 7
) (
  input logic              clk,
  input logic              rst,
  mem_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic              last_d, last_d_nxt;   // 1: data port got the most recent grant
  logic              gnt_d, gnt_d_nxt;     // port owning the current operation
  logic              we_q, we_nxt;
  logic              oor_q, oor_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] din_q, din_nxt;
  logic              re_q, re_nxt;
  logic              wr_q, wr_nxt;
  logic              if_ack_q, if_ack_nxt;
  logic              d_ack_q, d_ack_nxt;
  logic              err_q, err_nxt;
  logic              busy_q, busy_nxt;
  logic [DATA_W-1:0] rdata_q, rdata_nxt;

  logic              sel_d;
  logic              sel_we;
  logic              sel_oor;
  logic [ADDR_W-1:0] sel_addr;

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    gnt_d_nxt  = gnt_d;
    we_nxt     = we_q;
    oor_nxt    = oor_q;
    addr_nxt   = addr_q;
    din_nxt    = din_q;
    re_nxt     = 1'b0;
    wr_nxt     = 1'b0;
    if_ack_nxt = 1'b0;
    d_ack_nxt  = 1'b0;
    err_nxt    = 1'b0;
    rdata_nxt  = rdata_q;
    sel_d      = 1'b0;
    sel_we     = 1'b0;
    sel_oor    = 1'b0;
    sel_addr   = '0;

    case (state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          // On a tie the port that did not win last time gets the grant.
          sel_d    = bus.d_req && (!bus.if_req || !last_d);
          sel_addr = sel_d ? bus.d_addr : bus.if_addr;
          sel_we   = sel_d && bus.d_we;
          sel_oor  = |sel_addr[ADDR_W-1:DEPTH_LOG2];
          gnt_d_nxt  = sel_d;
          last_d_nxt = sel_d;
          we_nxt     = sel_we;
          oor_nxt    = sel_oor;
          addr_nxt   = sel_addr;
          if (sel_we && !sel_oor) din_nxt = bus.d_wdata;
          // Enables are set here so they are registered high for exactly the ISSUE cycle.
          re_nxt    = !sel_we && !sel_oor;
          wr_nxt    = sel_we && !sel_oor;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!we_q && !oor_q) begin
          state_nxt = WAIT;
        end else begin
          state_nxt  = DONE;
          if_ack_nxt = !gnt_d;
          d_ack_nxt  = gnt_d;
          err_nxt    = oor_q;
          if (oor_q) rdata_nxt = '0;
        end
      end
      WAIT: begin
        // Memory output is valid this cycle; capture it for the DONE cycle.
        state_nxt  = DONE;
        rdata_nxt  = bus.mem_dout;
        if_ack_nxt = !gnt_d;
        d_ack_nxt  = gnt_d;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      gnt_d    <= 1'b0;
      we_q     <= 1'b0;
      oor_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      re_q     <= 1'b0;
      wr_q     <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state    <= state_nxt;
      last_d   <= last_d_nxt;
      gnt_d    <= gnt_d_nxt;
      we_q     <= we_nxt;
      oor_q    <= oor_nxt;
      addr_q   <= addr_nxt;
      din_q    <= din_nxt;
      re_q     <= re_nxt;
      wr_q     <= wr_nxt;
      if_ack_q <= if_ack_nxt;
      d_ack_q  <= d_ack_nxt;
      err_q    <= err_nxt;
      busy_q   <= busy_nxt;
      rdata_q  <= rdata_nxt;
    end
  end

  assign bus.if_ack   = if_ack_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign bus.mem_re   = re_q;
  assign bus.mem_we   = wr_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
`timescale 1ns/1ps
module tb_mem_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_access_arbiter_if bus ();

  mem_access_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // ---------------- memory with registered one-cycle read ----------------
  logic [17:0] mem    [128];
  logic [17:0] shadow [128];
  logic        mem_init;

  function automatic logic [17:0] init_val(int i);
    if (i == 20) return 18'h3FFFF;
    return 18'((i * 37 + 5) ^ (i << 9));
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
    end else begin
      if (bus.mem_we) mem[bus.mem_addr[6:0]] <= bus.mem_din;
      if (bus.mem_re) bus.mem_dout <= mem[bus.mem_addr[6:0]];
    end
  end

  // ---------------- reference model state ----------------
  logic [17:0] m_rdata;
  bit          m_last_d;

  // ---------------- invariants checked every cycle ----------------
  always @(negedge clk) begin
    if (rst) begin
      n_chk++;
      if (((bus.mem_re && bus.mem_we) !== 1'b0) || ((bus.if_ack && bus.d_ack) !== 1'b0) ||
          (((bus.mem_re || bus.mem_we) && !bus.busy) !== 1'b0))
        $display("FAIL invariant t=%0t: re=%b we=%b if_ack=%b d_ack=%b busy=%b, required no overlap",
                 $time, bus.mem_re, bus.mem_we, bus.if_ack, bus.d_ack, bus.busy);
      else n_pass++;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && bus.busy; k++) step();
  endtask

  function automatic logic [12:0] rand_addr();
    logic [12:0] a;
    a = 13'($urandom_range(0, 127));
    if ($urandom_range(0, 5) == 0) a[12:7] = 6'($urandom_range(1, 63));
    return a;
  endfunction

  // Drives one request from idle and records what the DUT does (no checking here).
  task automatic run_one(input bit is_d, input bit we, input logic [12:0] addr, input logic [17:0] wd,
                         output int ack_cyc, output bit ack_d, output bit err_o, output logic [17:0] rd_o,
                         output int re_cnt, output int we_cnt, output int en_cyc,
                         output logic [12:0] en_addr, output logic [17:0] en_din, output bit busy_gap);
    wait_idle();
    ack_cyc = -1; ack_d = 0; err_o = 0; rd_o = '0; re_cnt = 0; we_cnt = 0; en_cyc = -1;
    en_addr = '0; en_din = '0; busy_gap = 0;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    for (int c = 1; c <= 12; c++) begin
      step();
      if (bus.mem_re) begin re_cnt++; en_cyc = c; en_addr = bus.mem_addr; end
      if (bus.mem_we) begin we_cnt++; en_cyc = c; en_addr = bus.mem_addr; en_din = bus.mem_din; end
      if (!bus.busy) busy_gap = 1;
      if (bus.if_ack || bus.d_ack) begin
        ack_cyc = c; ack_d = bus.d_ack; err_o = bus.err; rd_o = bus.rdata;
        break;
      end
    end
    bus.d_req = 1'b0;
    bus.if_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; mem_init = 1'b1;
    step(); step();
    mem_init = 1'b0;
    for (int i = 0; i < 128; i++) shadow[i] = init_val(i);
    m_rdata = '0; m_last_d = 0;
    n_chk++;
    if ({bus.if_ack, bus.d_ack, bus.err, bus.busy, bus.mem_re, bus.mem_we} !== 6'b0)
      $display("FAIL reset_flags: got %b required 000000",
               {bus.if_ack, bus.d_ack, bus.err, bus.busy, bus.mem_re, bus.mem_we});
    else n_pass++;
    n_chk++;
    if ({bus.mem_addr, bus.mem_din} !== 31'b0)
      $display("FAIL reset_mem_bus: got addr=%h din=%h required 0", bus.mem_addr, bus.mem_din);
    else n_pass++;
    n_chk++;
    if (bus.rdata !== 18'h0) $display("FAIL reset_rdata: got %h required 0", bus.rdata);
    else n_pass++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_fetch_read();
    int ac, rc, wc, ec; bit ad, er, bg; logic [17:0] rd, ed; logic [12:0] ea;
    run_one(0, 0, 13'd20, '0, ac, ad, er, rd, rc, wc, ec, ea, ed, bg);
    m_rdata = shadow[20]; m_last_d = 0;
    n_chk++;
    if (ac !== 3 || ad !== 1'b0) $display("FAIL fetch_ack: got cyc=%0d data=%b required cyc=3 data=0", ac, ad);
    else n_pass++;
    n_chk++;
    if (rd !== 18'h3FFFF || er !== 1'b0) $display("FAIL fetch_rdata: got %h err=%b required 3ffff err=0", rd, er);
    else n_pass++;
    n_chk++;
    if (rc !== 1 || wc !== 0 || ec !== 1 || ea !== 13'd20)
      $display("FAIL fetch_mem_re: got re=%0d we=%0d at %0d addr=%0d required re=1 we=0 at 1 addr=20", rc, wc, ec, ea);
    else n_pass++;
    n_chk++;
    if (bg !== 1'b0) $display("FAIL fetch_busy: got busy gap=%b required 0", bg);
    else n_pass++;
  endtask

  task automatic test_store_load();
    int ac, rc, wc, ec; bit ad, er, bg; logic [17:0] rd, ed; logic [12:0] ea;
    run_one(1, 1, 13'd21, 18'h00005, ac, ad, er, rd, rc, wc, ec, ea, ed, bg);
    shadow[21] = 18'h00005; m_last_d = 1;
    n_chk++;
    if (ac !== 2 || ad !== 1'b1 || er !== 1'b0)
      $display("FAIL store_ack: got cyc=%0d data=%b err=%b required cyc=2 data=1 err=0", ac, ad, er);
    else n_pass++;
    n_chk++;
    if (wc !== 1 || rc !== 0 || ec !== 1 || ed !== 18'h00005 || ea !== 13'd21)
      $display("FAIL store_mem_we: got we=%0d re=%0d at %0d din=%h required we=1 at 1 din=00005", wc, rc, ec, ed);
    else n_pass++;
    n_chk++;
    if (rd !== m_rdata) $display("FAIL store_rdata_kept: got %h required %h", rd, m_rdata);
    else n_pass++;
    run_one(0, 0, 13'd21, '0, ac, ad, er, rd, rc, wc, ec, ea, ed, bg);
    m_rdata = shadow[21]; m_last_d = 0;
    n_chk++;
    if (ac !== 3 || ad !== 1'b0 || rd !== 18'h00005)
      $display("FAIL load_after_store: got cyc=%0d data=%b rdata=%h required cyc=3 data=0 rdata=00005", ac, ad, rd);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    int ac, rc, wc, ec; bit ad, er, bg; logic [17:0] rd, ed; logic [12:0] ea;
    run_one(1, 0, 13'h0080, '0, ac, ad, er, rd, rc, wc, ec, ea, ed, bg);
    m_rdata = '0; m_last_d = 1;
    n_chk++;
    if (ac !== 2 || ad !== 1'b1 || er !== 1'b1 || rd !== 18'h0)
      $display("FAIL oor_ack: got cyc=%0d data=%b err=%b rdata=%h required cyc=2 data=1 err=1 rdata=0", ac, ad, er, rd);
    else n_pass++;
    n_chk++;
    if (rc !== 0 || wc !== 0) $display("FAIL oor_no_mem: got re=%0d we=%0d required 0 0", rc, wc);
    else n_pass++;
  endtask

  task automatic test_contention();
    int ack_c[$]; bit ack_p[$]; logic [17:0] ack_r[$];
    logic [12:0] fa, da;
    fa = 13'd33; da = 13'd34;
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = fa;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = da;
    step();
    m_rdata = '0; m_last_d = 0;
    rst = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (bus.if_ack || bus.d_ack) begin
        ack_c.push_back(c); ack_p.push_back(bus.d_ack); ack_r.push_back(bus.rdata);
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    n_chk++;
    if (ack_c.size() !== 4) $display("FAIL contention_count: got %0d acks required 4", ack_c.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < ack_c.size(); i++) begin
      bit xd;
      xd = (i % 2 == 0);
      n_chk++;
      if (ack_c[i] !== 3 + 4 * i || ack_p[i] !== xd || ack_r[i] !== (xd ? shadow[da] : shadow[fa]))
        $display("FAIL contention_ack%0d: got cyc=%0d data=%b rdata=%h required cyc=%0d data=%b rdata=%h",
                 i, ack_c[i], ack_p[i], ack_r[i], 3 + 4 * i, xd, xd ? shadow[da] : shadow[fa]);
      else n_pass++;
    end
    m_last_d = 0; m_rdata = shadow[fa];
  endtask

  task automatic test_reset_mid_op();
    int ac, rc, wc, ec, stray; bit ad, er, bg; logic [17:0] rd, ed, wd; logic [12:0] ea;
    wd = 18'($urandom);
    wait_idle();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 13'd30; bus.d_wdata = wd;
    step();
    n_chk++;
    if (bus.mem_we !== 1'b1) $display("FAIL midrst_issue: got mem_we=%b required 1", bus.mem_we);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({bus.mem_we, bus.mem_re, bus.busy, bus.if_ack, bus.d_ack, bus.err} !== 6'b0)
      $display("FAIL midrst_flags: got we=%b re=%b busy=%b acks=%b%b err=%b required all 0",
               bus.mem_we, bus.mem_re, bus.busy, bus.if_ack, bus.d_ack, bus.err);
    else n_pass++;
    n_chk++;
    if ({bus.mem_addr, bus.mem_din, bus.rdata} !== 49'b0)
      $display("FAIL midrst_data: got addr=%h din=%h rdata=%h required 0", bus.mem_addr, bus.mem_din, bus.rdata);
    else n_pass++;
    bus.d_req = 1'b0;
    m_rdata = '0; m_last_d = 0;
    @(negedge clk);
    step();
    rst = 1'b1;
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.if_ack || bus.d_ack || bus.busy) stray++;
    end
    n_chk++;
    if (stray !== 0) $display("FAIL midrst_no_ack: got %0d active cycles required 0", stray);
    else n_pass++;
    run_one(0, 0, 13'd30, '0, ac, ad, er, rd, rc, wc, ec, ea, ed, bg);
    m_rdata = shadow[30];
    n_chk++;
    if (ac !== 3 || rd !== shadow[30]) $display("FAIL midrst_write_lost: got cyc=%0d rdata=%h required cyc=3 rdata=%h", ac, rd, shadow[30]);
    else n_pass++;
    run_one(1, 1, 13'd30, wd, ac, ad, er, rd, rc, wc, ec, ea, ed, bg);
    shadow[30] = wd; m_last_d = 1;
    n_chk++;
    if (ac !== 2 || ad !== 1'b1 || wc !== 1 || ed !== wd || rd !== m_rdata)
      $display("FAIL midrst_reissue: got cyc=%0d data=%b we=%0d din=%h rdata=%h required 2 1 1 %h %h", ac, ad, wc, ed, rd, wd, m_rdata);
    else n_pass++;
    run_one(0, 0, 13'd30, '0, ac, ad, er, rd, rc, wc, ec, ea, ed, bg);
    m_rdata = shadow[30]; m_last_d = 0;
    n_chk++;
    if (rd !== wd) $display("FAIL midrst_readback: got %h required %h", rd, wd);
    else n_pass++;
  endtask

  task automatic test_ack_handshake();
    logic [17:0] w1, w2;
    int active;
    w1 = 18'($urandom); w2 = 18'($urandom);
    wait_idle();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 13'd40; bus.d_wdata = w1;
    for (int c = 1; c <= 11; c++) begin
      step();
      n_chk++;
      if ({bus.d_ack, bus.mem_we} !== {(c % 3 == 2), (c % 3 == 1)})
        $display("FAIL held_req_c%0d: got ack=%b we=%b required ack=%b we=%b",
                 c, bus.d_ack, bus.mem_we, (c % 3 == 2), (c % 3 == 1));
      else n_pass++;
    end
    bus.d_req = 1'b0;
    shadow[40] = w1; m_last_d = 1;
    wait_idle();
    bus.d_req = 1'b1; bus.d_addr = 13'd41; bus.d_wdata = w2;
    step(); step();
    n_chk++;
    if (bus.d_ack !== 1'b1) $display("FAIL drop_first_ack: got %b required 1", bus.d_ack);
    else n_pass++;
    step();
    bus.d_req = 1'b0;
    shadow[41] = w2;
    active = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.mem_we || bus.mem_re || bus.d_ack || bus.busy) active++;
    end
    n_chk++;
    if (active !== 0) $display("FAIL dropped_req_no_second: got %0d active cycles required 0", active);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int mode, n, t, idx, re_seen, we_seen, exp_re, exp_we;
      bit ord_d[2]; int exp_cyc[2]; bit exp_err[2]; logic [17:0] exp_rd[2];
      logic [12:0] fa, da; bit dwe; logic [17:0] dwd;
      mode = $urandom_range(0, 2);
      fa = rand_addr(); da = rand_addr(); dwe = 1'($urandom); dwd = 18'($urandom);
      // model: serve order, then per-access latency/result from the access rules
      n = (mode == 2) ? 2 : 1;
      if (mode == 0) ord_d[0] = 0;
      else if (mode == 1) ord_d[0] = 1;
      else begin ord_d[0] = !m_last_d; ord_d[1] = m_last_d; end
      t = 0; exp_re = 0; exp_we = 0;
      for (int i = 0; i < n; i++) begin
        logic [12:0] a; bit wr, oor;
        a = ord_d[i] ? da : fa;
        wr = ord_d[i] && dwe;
        oor = (a >= 13'd128);
        if (oor) m_rdata = '0;
        else if (wr) begin shadow[a[6:0]] = dwd; exp_we++; end
        else begin m_rdata = shadow[a[6:0]]; exp_re++; end
        exp_cyc[i] = t + ((!wr && !oor) ? 3 : 2);
        exp_err[i] = oor;
        exp_rd[i] = m_rdata;
        t = exp_cyc[i] + 1;
        m_last_d = ord_d[i];
      end
      wait_idle();
      bus.if_req = (mode != 1); bus.if_addr = fa;
      bus.d_req = (mode != 0); bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
      idx = 0; re_seen = 0; we_seen = 0;
      for (int c = 1; c <= 30; c++) begin
        step();
        if (bus.mem_re) re_seen++;
        if (bus.mem_we) we_seen++;
        if (bus.if_ack || bus.d_ack) begin
          if (idx < n) begin
            n_chk++;
            if (c !== exp_cyc[idx] || bus.d_ack !== ord_d[idx])
              $display("FAIL rand%0d_ack%0d: got cyc=%0d data=%b required cyc=%0d data=%b",
                       it, idx, c, bus.d_ack, exp_cyc[idx], ord_d[idx]);
            else n_pass++;
            n_chk++;
            if (bus.err !== exp_err[idx] || bus.rdata !== exp_rd[idx])
              $display("FAIL rand%0d_data%0d: got err=%b rdata=%h required err=%b rdata=%h",
                       it, idx, bus.err, bus.rdata, exp_err[idx], exp_rd[idx]);
            else n_pass++;
          end
          if (bus.d_ack) bus.d_req = 1'b0; else bus.if_req = 1'b0;
          idx++;
          if (idx >= n) break;
        end
      end
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      n_chk++;
      if (idx !== n || re_seen !== exp_re || we_seen !== exp_we)
        $display("FAIL rand%0d_counts: got acks=%0d re=%0d we=%0d required %0d %0d %0d",
                 it, idx, re_seen, we_seen, n, exp_re, exp_we);
      else n_pass++;
    end
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    mem_init = 1'b1;
    @(negedge clk);
    test_reset();
    test_fetch_read();
    test_store_load();
    test_out_of_range();
    test_contention();
    test_reset_mid_op();
    test_ack_handshake();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Sits directly upstream of the processor's single-port 18-bit word memory and is the only block that drives it. It arbitrates between the instruction-fetch port and the data (load/store) port, and issues exactly one memory operation at a time. It sequences the memory's registered one-cycle read latency and returns read data with a per-port acknowledge. Addresses beyond the physical array are rejected without touching memory.

## Interface
Parameters:
- DATA_W, 18, memory word width
- ADDR_W, 13, address width
- DEPTH_LOG2, 7, log2 of implemented words (128); higher address bits must be zero

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_ack  out  1  one-cycle pulse: fetch complete, rdata/err valid
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse: data access complete
- rdata  out  DATA_W  read data, valid in ack cycle of a read
- err  out  1  pulse with ack: address out of range
- busy  out  1  high in any state other than IDLE
- mem_addr  out  ADDR_W  to memory address
- mem_din  out  DATA_W  to memory write data
- mem_re  out  1  to memory read enable
- mem_we  out  1  to memory write enable
- mem_dout  in  DATA_W  from memory, registered, valid the cycle after mem_re

## Operation
- FSM: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE: if either req is high, grant one port. Latch addr, we (fetch always reads), wdata and the range check (addr[ADDR_W-1:DEPTH_LOG2] != 0). Go to ISSUE. With no request, stay in IDLE.
- Arbitration: a single requester always wins. When both request, the port not granted last wins. last_grant resets to fetch, so the data port wins the first tie.
- ISSUE, 1 cycle:
  - In range: mem_re=1 for a read or mem_we=1 for a write, with mem_addr/mem_din driven.
  - Out of range: both enables stay 0.
  - Next state: read → WAIT; write or out of range → DONE.
- WAIT, 1 cycle: mem_dout is valid. Capture it into the rdata register at the end of the cycle. Next state DONE.
- DONE, 1 cycle:
  - Pulse the granted port's ack.
  - err=1 if the access was out of range; in that case rdata=0.
  - Writes leave rdata unchanged.
  - Next state IDLE.
- Invariants:
  - mem_re and mem_we are never high together.
  - At most one ack per cycle.
  - Enables are high only in ISSUE.
  - Outside ISSUE, mem_addr/mem_din hold their last values.
- A request still high in the IDLE cycle after its ack is treated as a new request.
- Requests arriving during busy are not sampled until IDLE; nothing is queued.

## Timing
- Reset values: state=IDLE, last_grant=fetch. if_ack, d_ack, err, busy, mem_re, mem_we all 0. mem_addr, mem_din, rdata all 0.
- Reset is asynchronous: asserting rst in any state forces the reset values immediately. A mid-ISSUE write may therefore be lost. No ack is issued for the aborted request, and the requester must re-request.
- Read latency: req first sampled in IDLE at cycle T → ISSUE T+1 → WAIT T+2 → ack and rdata at T+3.
- Write or out-of-range latency: ack at T+2.
- Back-to-back:
  - A held request re-sampled in the IDLE following DONE gives one access per 4 cycles for reads and per 3 cycles for writes.
  - With both ports requesting, grants alternate.
- The memory sees mem_re for exactly one cycle per read.

## Test plan
- Fetch read in range: after the memory is preloaded, if_req with if_addr=20 sampled at T. Required: mem_re high only at T+1, if_ack and rdata=18'h3FFFF at T+3, busy high T+1..T+3.
- Store then load: d_req, d_we=1, d_addr=21, d_wdata=18'h00005. Required: mem_we at T+1 and d_ack at T+2. Then a fetch of 21 returns rdata=18'h00005 with its if_ack.
- Contention: if_req and d_req both held from reset, both reads. Required: grant order data, fetch, data, fetch. Acks alternate every 4 cycles, and the two acks never coincide.
- Out of range: d_req load with d_addr=13'h0080. Required: mem_re and mem_we never high, d_ack with err=1 and rdata=0 at T+2.
- Reset mid-op: drop rst low during the ISSUE of a store. Required: mem_we falls immediately, all outputs return to reset values, and no ack appears. The same request reissued after reset completes normally.
- Ack handshake: requester drops d_req in the cycle after d_ack. Required: no second access. Holding d_req instead produces a second access starting in that IDLE cycle.
